// File: rtl/scp_trace_buffer_if.sv
// Capture-side and drain-side signals of the commit-trace buffer.
// The slave modport is the buffer; the master modport is the core/sink side.
interface scp_trace_buffer_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = 16,
  parameter int DROP_W  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               cap_en;
  logic               cap_valid;
  logic [ADDR_W-1:0]  cap_pc;
  logic [INSTR_W-1:0] cap_instr;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [SEQ_W-1:0]   out_seq;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic [DROP_W-1:0]  drop_cnt;

  modport master (
    output cap_en, cap_valid, cap_pc, cap_instr, out_ready,
    input  out_valid, out_pc, out_instr, out_seq, level, full, drop_cnt
  );

  modport slave (
    input  cap_en, cap_valid, cap_pc, cap_instr, out_ready,
    output out_valid, out_pc, out_instr, out_seq, level, full, drop_cnt
  );
endinterface

// File: rtl/scp_trace_buffer.sv
// Commit-trace FIFO: stamps each retiring pc/instr with a cycle number and queues it for a sink.
// Optional macro TRACE_FILTER_EN suppresses repeated captures of the last accepted pc.
module scp_trace_buffer #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int SEQ_W   = 16,
  parameter int DROP_W  = 8
) (
  input  logic                clk,
  input  logic                rstb,
  scp_trace_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {D_COUNT, D_SAT} drop_st_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

  logic [ADDR_W-1:0]  mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [SEQ_W-1:0]   mem_seq   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q, level_nxt;
  logic [SEQ_W-1:0]  seq;
  logic [DROP_W-1:0] drop_q, drop_nxt;
  drop_st_t          drop_st, drop_st_nxt;
  logic              push_req, push_eff, push_acc, push_drop, pop;
  logic              is_full, is_valid;

  assign push_req = bus.cap_en & bus.cap_valid;

`ifdef TRACE_FILTER_EN
  logic [ADDR_W-1:0] last_pc;
  logic              last_vld;

  // A repeat of the last stored pc is swallowed, neither stored nor counted as a drop.
  assign push_eff = push_req & ~(last_vld & (bus.cap_pc == last_pc));

  always_ff @(posedge clk) begin
    if (rstb)          last_vld <= 1'b0;
    else if (push_acc) last_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_acc && !rstb) last_pc <= bus.cap_pc;
  end
`else
  assign push_eff = push_req;
`endif

  assign is_full   = (level_q == LVL_FULL);
  assign is_valid  = (level_q != '0);
  assign pop       = is_valid & bus.out_ready;
  assign push_acc  = push_eff & (~is_full | pop);
  assign push_drop = push_eff & is_full & ~pop;

  always_comb begin
    level_nxt = level_q;
    case ({push_acc, pop})
      2'b10:   level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_comb begin
    drop_st_nxt = drop_st;
    drop_nxt    = drop_q;
    case (drop_st)
      D_COUNT: begin
        if (push_drop) begin
          drop_nxt = sat_inc(drop_q);
          if (drop_nxt == DROP_MAX) drop_st_nxt = D_SAT;
        end
      end
      D_SAT:   drop_nxt = DROP_MAX;
      default: drop_st_nxt = D_COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      seq     <= '0;
      drop_q  <= '0;
      drop_st <= D_COUNT;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_nxt;
      seq     <= seq + SEQ_W'(1);
      drop_q  <= drop_nxt;
      drop_st <= drop_st_nxt;
    end
  end

  // Storage carries no reset; an empty FIFO masks the head fields to zero instead.
  always_ff @(posedge clk) begin
    if (push_acc && !rstb) begin
      mem_pc[wr_ptr]    <= bus.cap_pc;
      mem_instr[wr_ptr] <= bus.cap_instr;
      mem_seq[wr_ptr]   <= seq;
    end
  end

  assign bus.out_valid = is_valid;
  assign bus.full      = is_full;
  assign bus.level     = level_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.out_pc    = is_valid ? mem_pc[rd_ptr]    : '0;
  assign bus.out_instr = is_valid ? mem_instr[rd_ptr] : '0;
  assign bus.out_seq   = is_valid ? mem_seq[rd_ptr]   : '0;

endmodule

// File: tb/tb_scp_trace_buffer.sv
// Directed bench for scp_trace_buffer: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_scp_trace_buffer;
  localparam int ADDR_W   = 32;
  localparam int INSTR_W  = 32;
  localparam int DEPTH    = 16;
  localparam int SEQ_W    = 16;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;
`ifdef TRACE_FILTER_EN
  localparam int EXP_T6 = 2;
`else
  localparam int EXP_T6 = 5;
`endif

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic [SEQ_W-1:0]   seq;
  } ent_t;

  logic clk = 1'b0;
  logic rstb;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  ent_t             mq[$];
  logic [SEQ_W-1:0] mseq = '0;
  int               mdrop = 0;
`ifdef TRACE_FILTER_EN
  logic [ADDR_W-1:0] mlast_pc;
  bit                mlast_vld;
`endif

  scp_trace_buffer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                        .SEQ_W(SEQ_W), .DROP_W(DROP_W)) bus ();

  scp_trace_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                     .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [ADDR_W-1:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus counters, advanced once per rising edge.
  initial forever begin
    @(posedge clk);
    if (rstb) begin
      mq.delete();
      mseq  = '0;
      mdrop = 0;
`ifdef TRACE_FILTER_EN
      mlast_vld = 1'b0;
`endif
    end else begin
      int occ;
      bit do_pop, req;
      occ    = mq.size();
      do_pop = (occ != 0) && bus.out_ready;
      req    = bus.cap_en && bus.cap_valid;
`ifdef TRACE_FILTER_EN
      if (mlast_vld && (bus.cap_pc == mlast_pc)) req = 1'b0;
`endif
      if (do_pop) void'(mq.pop_front());
      if (req) begin
        if (occ < DEPTH || do_pop) begin
          mq.push_back('{pc: bus.cap_pc, instr: bus.cap_instr, seq: mseq});
`ifdef TRACE_FILTER_EN
          mlast_pc  = bus.cap_pc;
          mlast_vld = 1'b1;
`endif
        end else if (mdrop < DROP_MAX) begin
          mdrop++;
        end
      end
      mseq++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("m_level", 64'(bus.level), 64'(mq.size()));
      check("m_full", 64'(bus.full), 64'(mq.size() == DEPTH));
      check("m_drop", 64'(bus.drop_cnt), 64'(mdrop));
      if (mq.size() != 0) begin
        check("m_head_pc", 64'(bus.out_pc), 64'(mq[0].pc));
        check("m_head_instr", 64'(bus.out_instr), 64'(mq[0].instr));
        check("m_head_seq", 64'(bus.out_seq), 64'(mq[0].seq));
      end else begin
        check("m_idle_pc", 64'(bus.out_pc), 64'(0));
        check("m_idle_seq", 64'(bus.out_seq), 64'(0));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_cap(input bit v, input logic [ADDR_W-1:0] pc);
    bus.cap_valid = v;
    bus.cap_pc    = pc;
    bus.cap_instr = instr_of(pc);
  endtask

  initial begin
    rstb          = 1'b1;
    bus.cap_en    = 1'b1;
    bus.out_ready = 1'b0;
    set_cap(1'b0, '0);
    step(2);
    at_neg();
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_level", 64'(bus.level), 64'(0));
    check("rst_full", 64'(bus.full), 64'(0));
    check("rst_drop", 64'(bus.drop_cnt), 64'(0));
    check("rst_pc", 64'(bus.out_pc), 64'(0));
    rstb   = 1'b0;
    chk_en = 1'b1;
    step(1);

    // Three pushes, then drain in order.
    for (int i = 0; i < 3; i++) begin
      set_cap(1'b1, 32'(4 * i));
      step(1);
    end
    set_cap(1'b0, '0);
    at_neg();
    check("t1_level", 64'(bus.level), 64'(3));
    check("t1_pc0", 64'(bus.out_pc), 64'(0));
    check("t1_seq0", 64'(bus.out_seq), 64'(1));
    check("t1_instr0", 64'(bus.out_instr), 64'(32'hC0DE_0013));
    bus.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step(1);
      at_neg();
      check("t1_drain_pc", 64'(bus.out_pc), 64'(4 * i));
    end
    step(1);
    at_neg();
    check("t1_empty_level", 64'(bus.level), 64'(0));
    check("t1_empty_valid", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // Overfill: 20 pushes into 16 entries.
    for (int i = 0; i < 20; i++) begin
      set_cap(1'b1, 32'(32'h100 + 4 * i));
      step(1);
      if (i == 15) begin
        at_neg();
        check("t2_full16", 64'(bus.full), 64'(1));
        check("t2_drop16", 64'(bus.drop_cnt), 64'(0));
      end
    end
    set_cap(1'b0, '0);
    at_neg();
    check("t2_drop", 64'(bus.drop_cnt), 64'(4));
    check("t2_level", 64'(bus.level), 64'(16));
    check("t2_head", 64'(bus.out_pc), 64'(32'h100));

    // Full with simultaneous push and pop.
    set_cap(1'b1, 32'h200);
    bus.out_ready = 1'b1;
    step(1);
    set_cap(1'b0, '0);
    bus.out_ready = 1'b0;
    at_neg();
    check("t3_level", 64'(bus.level), 64'(16));
    check("t3_drop", 64'(bus.drop_cnt), 64'(4));
    check("t3_head", 64'(bus.out_pc), 64'(32'h104));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain_pc", 64'(bus.out_pc), (i < 15) ? 64'(32'h104 + 4 * i) : 64'(32'h200));
      step(1);
      at_neg();
    end
    check("t3_empty", 64'(bus.out_valid), 64'(0));

    // Push into empty FIFO while the sink is ready: no bypass.
    set_cap(1'b1, 32'h300);
    check("t4_same_cycle", 64'(bus.out_valid), 64'(0));
    step(1);
    set_cap(1'b0, '0);
    at_neg();
    check("t4_next_valid", 64'(bus.out_valid), 64'(1));
    check("t4_next_pc", 64'(bus.out_pc), 64'(32'h300));
    step(1);
    bus.out_ready = 1'b0;
    at_neg();
    check("t4_drained", 64'(bus.level), 64'(0));

    // Reset mid-drain with a push and pop presented in the reset cycle.
    for (int i = 0; i < 8; i++) begin
      set_cap(1'b1, 32'(32'h400 + 4 * i));
      step(1);
    end
    set_cap(1'b0, '0);
    bus.out_ready = 1'b1;
    step(3);
    at_neg();
    check("t5_pre_level", 64'(bus.level), 64'(5));
    rstb = 1'b1;
    set_cap(1'b1, 32'h4F0);
    step(1);
    rstb = 1'b0;
    set_cap(1'b0, '0);
    bus.out_ready = 1'b0;
    at_neg();
    check("t5_level", 64'(bus.level), 64'(0));
    check("t5_valid", 64'(bus.out_valid), 64'(0));
    check("t5_drop", 64'(bus.drop_cnt), 64'(0));
    check("t5_pc", 64'(bus.out_pc), 64'(0));
    step(1);
    set_cap(1'b1, 32'h500);
    step(1);
    set_cap(1'b0, '0);
    at_neg();
    check("t5_seq", 64'(bus.out_seq), 64'(1));
    check("t5_pc_new", 64'(bus.out_pc), 64'(32'h500));
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;

    // Self-loop halt: same pc four times, then the next pc.
    for (int i = 0; i < 5; i++) begin
      set_cap(1'b1, (i < 4) ? 32'h40 : 32'h44);
      step(1);
    end
    set_cap(1'b0, '0);
    at_neg();
    check("t6_level", 64'(bus.level), 64'(EXP_T6));
    check("t6_drop", 64'(bus.drop_cnt), 64'(0));
    check("t6_head", 64'(bus.out_pc), 64'(32'h40));
    bus.out_ready = 1'b1;
    step(6);
    bus.out_ready = 1'b0;

    // Capture gated off by cap_en.
    bus.cap_en = 1'b0;
    set_cap(1'b1, 32'h600);
    step(1);
    set_cap(1'b0, '0);
    bus.cap_en = 1'b1;
    at_neg();
    check("t7_gated", 64'(bus.level), 64'(0));

    // Drop counter saturation.
    for (int i = 0; i < DEPTH + 260; i++) begin
      set_cap(1'b1, 32'(32'h1000 + 4 * i));
      step(1);
    end
    set_cap(1'b0, '0);
    at_neg();
    check("t8_sat", 64'(bus.drop_cnt), 64'(255));
    check("t8_full", 64'(bus.full), 64'(1));
    rstb = 1'b1;
    step(1);
    rstb = 1'b0;
    at_neg();
    check("t8_rst_drop", 64'(bus.drop_cnt), 64'(0));
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
